// File: rtl/spi_flash_reader_pkg.sv
// Shared constants, FSM encoding and byte-sequencing helper for spi_flash_reader.
// FLASH_FAST_READ_EN selects the 0x0B fast-read command with one dummy byte.
package spi_flash_reader_pkg;

  localparam logic [7:0] FLASH_CMD_READ      = 8'h03;
  localparam logic [7:0] FLASH_CMD_FAST_READ = 8'h0B;

`ifdef FLASH_FAST_READ_EN
  localparam logic [7:0] FLASH_CMD    = FLASH_CMD_FAST_READ;
  localparam int         HEADER_BYTES = 5;
`else
  localparam logic [7:0] FLASH_CMD    = FLASH_CMD_READ;
  localparam int         HEADER_BYTES = 4;
`endif

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CMD   = 4'd1,
    ST_ADDR2 = 4'd2,
    ST_ADDR1 = 4'd3,
    ST_ADDR0 = 4'd4,
`ifdef FLASH_FAST_READ_EN
    ST_DUMMY = 4'd5,
`endif
    ST_DATA  = 4'd6,
    ST_XFER  = 4'd7,
    ST_GAP   = 4'd8
  } state_t;

  // Byte state that follows a completed header byte.
  function automatic state_t next_byte_state(input state_t s);
    state_t n;
    n = ST_DATA;
    case (s)
      ST_CMD:   n = ST_ADDR2;
      ST_ADDR2: n = ST_ADDR1;
      ST_ADDR1: n = ST_ADDR0;
`ifdef FLASH_FAST_READ_EN
      ST_ADDR0: n = ST_DUMMY;
`else
      ST_ADDR0: n = ST_DATA;
`endif
      default:  n = ST_DATA;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spi_flash_reader_byte_fifo.sv
// Byte FIFO buffering received flash data; pointers wrap modulo DEPTH (power of two).
module spi_flash_reader_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty    = (cnt == '0);
  assign full     = (cnt == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && !full;
  assign count    = cnt;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/spi_flash_reader.sv
// SPI flash read sequencer: cmd + 24-bit address (+ dummy with FLASH_FAST_READ_EN),
// then N data bytes pushed into a byte FIFO for the loader.
//
// Handshakes: spi_start is a one-cycle pulse; a byte is complete on the first cycle
// spi_busy is low after having been seen high. The read port pops on rd_valid && rd_ready.
module spi_flash_reader
  import spi_flash_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CS_GAP     = 2
) (
  input  logic                          raw_clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [23:0]                   address,
  input  logic [7:0]                    length,
  output logic                          busy,
  output logic                          done,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          flash_cs_n,
  output logic                          spi_start,
  output logic [7:0]                    spi_data_tx,
  input  logic [7:0]                    spi_data_rx,
  input  logic                          spi_busy,
  output logic [3:0]                    state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int GW = $clog2(CS_GAP + 1);

  state_t        state, state_d;
  state_t        cur_byte, cur_byte_d;
  logic [23:0]   addr_q, addr_d;
  logic [8:0]    remaining, remaining_d;
  logic          seen_busy, seen_busy_d;
  logic [GW-1:0] gap_cnt, gap_cnt_d;
  logic          cs_n_q, cs_n_d;
  logic          start_q, start_d;
  logic [7:0]    tx_q, tx_d;
  logic          done_q, done_d;

  logic          fifo_push;
  logic          fifo_full;
  logic          fifo_empty;

  always_ff @(posedge raw_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      cur_byte  <= ST_CMD;
      addr_q    <= '0;
      remaining <= '0;
      seen_busy <= 1'b0;
      gap_cnt   <= '0;
      cs_n_q    <= 1'b1;
      start_q   <= 1'b0;
      tx_q      <= 8'h00;
      done_q    <= 1'b0;
    end else begin
      state     <= state_d;
      cur_byte  <= cur_byte_d;
      addr_q    <= addr_d;
      remaining <= remaining_d;
      seen_busy <= seen_busy_d;
      gap_cnt   <= gap_cnt_d;
      cs_n_q    <= cs_n_d;
      start_q   <= start_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state;
    cur_byte_d  = cur_byte;
    addr_d      = addr_q;
    remaining_d = remaining;
    seen_busy_d = seen_busy;
    gap_cnt_d   = gap_cnt;
    cs_n_d      = cs_n_q;
    start_d     = 1'b0;
    tx_d        = tx_q;
    done_d      = 1'b0;
    fifo_push   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // A start arriving while the master still drains a byte is dropped.
        if (start && !spi_busy) begin
          addr_d      = address;
          remaining_d = (length == 8'd0) ? 9'd256 : {1'b0, length};
          cs_n_d      = 1'b0;
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        tx_d       = FLASH_CMD;
        start_d    = 1'b1;
        cur_byte_d = ST_CMD;
        state_d    = ST_XFER;
      end
      ST_ADDR2: begin
        tx_d       = addr_q[23:16];
        start_d    = 1'b1;
        cur_byte_d = ST_ADDR2;
        state_d    = ST_XFER;
      end
      ST_ADDR1: begin
        tx_d       = addr_q[15:8];
        start_d    = 1'b1;
        cur_byte_d = ST_ADDR1;
        state_d    = ST_XFER;
      end
      ST_ADDR0: begin
        tx_d       = addr_q[7:0];
        start_d    = 1'b1;
        cur_byte_d = ST_ADDR0;
        state_d    = ST_XFER;
      end
`ifdef FLASH_FAST_READ_EN
      ST_DUMMY: begin
        tx_d       = 8'h00;
        start_d    = 1'b1;
        cur_byte_d = ST_DUMMY;
        state_d    = ST_XFER;
      end
`endif
      ST_DATA: begin
        // Only one byte is ever in flight, so a free slot now guarantees room on arrival.
        if (!fifo_full) begin
          tx_d       = 8'h00;
          start_d    = 1'b1;
          cur_byte_d = ST_DATA;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (spi_busy) begin
          seen_busy_d = 1'b1;
        end else if (seen_busy) begin
          seen_busy_d = 1'b0;
          if (cur_byte == ST_DATA) begin
            fifo_push   = 1'b1;
            remaining_d = remaining - 9'd1;
            if (remaining == 9'd1) begin
              done_d    = 1'b1;
              cs_n_d    = 1'b1;
              gap_cnt_d = '0;
              state_d   = ST_GAP;
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = next_byte_state(cur_byte);
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt == GW'(CS_GAP - 1)) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt + GW'(1);
        end
      end
      default: begin
        cs_n_d  = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  spi_flash_reader_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (raw_clk),
    .rst       (reset),
    .push      (fifo_push),
    .push_data (spi_data_rx),
    .pop       (rd_ready),
    .pop_data  (rd_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_level)
  );

  assign busy        = (state != ST_IDLE);
  assign done        = done_q;
  assign rd_valid    = !fifo_empty;
  assign flash_cs_n  = cs_n_q;
  assign spi_start   = start_q;
  assign spi_data_tx = tx_q;
  assign state_dbg   = state;

endmodule
